// File: rtl/key_voice_allocator_if.sv
// Key-event input bundle and tone-generator output bundle
// for the two-voice key allocator.
interface key_voice_allocator_if;
  logic        key_valid;
  logic [7:0]  key_code;
  logic        key_break;
  logic [15:0] freq1;
  logic [15:0] freq2;
  logic [8:0]  volume;
  logic        audio_ena;

  modport master (
    output key_valid,
    output key_code,
    output key_break,
    input  freq1,
    input  freq2,
    input  volume,
    input  audio_ena
  );

  modport slave (
    input  key_valid,
    input  key_code,
    input  key_break,
    output freq1,
    output freq2,
    output volume,
    output audio_ena
  );
endinterface

// File: rtl/key_voice_allocator.sv
// Maps scan codes to phase increments for two voice slots,
// with octave shift, volume stepping and oldest-voice stealing.
module key_voice_allocator #(
  parameter logic [8:0] VOL_DEFAULT = 9'd400,
  parameter logic [8:0] VOL_STEP    = 9'd16,
  parameter logic [8:0] VOL_MAX     = 9'd511
) (
  input  logic clk,
  input  logic reset,
  key_voice_allocator_if.slave bus
);

  logic              s1_busy_q, s1_busy_d;
  logic [7:0]        s1_code_q, s1_code_d;
  logic [15:0]       s1_inc_q, s1_inc_d;
  logic              s2_busy_q, s2_busy_d;
  logic [7:0]        s2_code_q, s2_code_d;
  logic [15:0]       s2_inc_q, s2_inc_d;
  logic              old_q, old_d;
  logic signed [2:0] oct_q, oct_d;
  logic [8:0]        vol_q, vol_d;
  logic [15:0]       freq1_q, freq1_d;
  logic [15:0]       freq2_q, freq2_d;
  logic              ena_q, ena_d;

  logic [15:0] base;
  logic [15:0] inc;
  logic [2:0]  oct_neg;
  logic [1:0]  oct_mag;
  logic [9:0]  vol_up;
  logic        is_note;
  logic        is_oct_dn;
  logic        is_oct_up;
  logic        is_vol_up;
  logic        is_vol_dn;
  logic        hit1;
  logic        hit2;
  logic        brk;
  logic [7:0]  code;

  assign code = bus.key_code;
  assign brk  = bus.key_break;

  always_comb begin
    base = '0;
    case (code)
      8'h1C:   base = 16'd357;
      8'h1B:   base = 16'd401;
      8'h23:   base = 16'd450;
      8'h2B:   base = 16'd477;
      8'h34:   base = 16'd535;
      8'h33:   base = 16'd601;
      8'h3B:   base = 16'd674;
      8'h42:   base = 16'd714;
      default: base = '0;
    endcase
  end

  assign is_note   = (base != '0);
  assign is_oct_dn = (code == 8'h1A);
  assign is_oct_up = (code == 8'h22);
  assign is_vol_up = (code == 8'h79);
  assign is_vol_dn = (code == 8'h7B);

  // Negative octaves shift right by the magnitude.
  assign oct_neg = -oct_q;
  assign oct_mag = oct_q[2] ? oct_neg[1:0] : oct_q[1:0];
  assign inc     = oct_q[2] ? (base >> oct_mag)
                            : (base << oct_mag);

  assign hit1   = s1_busy_q && (s1_code_q == code);
  assign hit2   = s2_busy_q && (s2_code_q == code);
  assign vol_up = {1'b0, vol_q} + {1'b0, VOL_STEP};

  always_comb begin
    s1_busy_d = s1_busy_q;
    s1_code_d = s1_code_q;
    s1_inc_d  = s1_inc_q;
    s2_busy_d = s2_busy_q;
    s2_code_d = s2_code_q;
    s2_inc_d  = s2_inc_q;
    old_d     = old_q;
    oct_d     = oct_q;
    vol_d     = vol_q;
    if (bus.key_valid) begin
      unique case (1'b1)
        is_note && !brk: begin
          if (!(hit1 || hit2)) begin
            if (!s1_busy_q) begin
              s1_busy_d = 1'b1;
              s1_code_d = code;
              s1_inc_d  = inc;
              old_d     = s2_busy_q;
            end else if (!s2_busy_q) begin
              s2_busy_d = 1'b1;
              s2_code_d = code;
              s2_inc_d  = inc;
              old_d     = 1'b0;
            end else if (!old_q) begin
              s1_code_d = code;
              s1_inc_d  = inc;
              old_d     = 1'b1;
            end else begin
              s2_code_d = code;
              s2_inc_d  = inc;
              old_d     = 1'b0;
            end
          end
        end
        is_note && brk: begin
          if (hit1) s1_busy_d = 1'b0;
          if (hit2) s2_busy_d = 1'b0;
          if (hit1 && s2_busy_q && !hit2)
            old_d = 1'b1;
        end
        is_oct_dn && !brk: begin
          if (oct_q != -3'sd2) oct_d = oct_q - 3'sd1;
        end
        is_oct_up && !brk: begin
          if (oct_q != 3'sd2) oct_d = oct_q + 3'sd1;
        end
        is_vol_up && !brk: begin
          if (vol_up > {1'b0, VOL_MAX}) vol_d = VOL_MAX;
          else vol_d = vol_up[8:0];
        end
        is_vol_dn && !brk: begin
          if (vol_q < VOL_STEP) vol_d = '0;
          else vol_d = vol_q - VOL_STEP;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    freq1_d = s1_busy_d ? s1_inc_d : '0;
    freq2_d = s2_busy_d ? s2_inc_d : '0;
    ena_d   = (freq1_d != '0) || (freq2_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_busy_q <= 1'b0;
      s1_code_q <= '0;
      s1_inc_q  <= '0;
      s2_busy_q <= 1'b0;
      s2_code_q <= '0;
      s2_inc_q  <= '0;
      old_q     <= 1'b0;
      oct_q     <= '0;
      vol_q     <= VOL_DEFAULT;
      freq1_q   <= '0;
      freq2_q   <= '0;
      ena_q     <= 1'b0;
    end else begin
      s1_busy_q <= s1_busy_d;
      s1_code_q <= s1_code_d;
      s1_inc_q  <= s1_inc_d;
      s2_busy_q <= s2_busy_d;
      s2_code_q <= s2_code_d;
      s2_inc_q  <= s2_inc_d;
      old_q     <= old_d;
      oct_q     <= oct_d;
      vol_q     <= vol_d;
      freq1_q   <= freq1_d;
      freq2_q   <= freq2_d;
      ena_q     <= ena_d;
    end
  end

  assign bus.freq1     = freq1_q;
  assign bus.freq2     = freq2_q;
  assign bus.volume    = vol_q;
  assign bus.audio_ena = ena_q;

endmodule

// File: tb/tb_key_voice_allocator.sv
// Scoreboard bench for key_voice_allocator: directed plan
// plus random key events against an abstract voice model.
module tb_key_voice_allocator;

  logic clk = 1'b0;
  logic reset;

  key_voice_allocator_if bus ();

  key_voice_allocator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int f1;
    int f2;
    int vol;
    int ena;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Abstract model: two voices, octave, volume.
  bit m_busy[2];
  int m_code[2];
  int m_inc[2];
  int m_old;
  int m_oct;
  int m_vol;

  function automatic int base_of(input int c);
    case (c)
      'h1C: return 357;
      'h1B: return 401;
      'h23: return 450;
      'h2B: return 477;
      'h34: return 535;
      'h33: return 601;
      'h3B: return 674;
      'h42: return 714;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string nm,
                       input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy[0] = 0;
    m_busy[1] = 0;
    m_code[0] = 0;
    m_code[1] = 0;
    m_inc[0]  = 0;
    m_inc[1]  = 0;
    m_old     = 0;
    m_oct     = 0;
    m_vol     = 400;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.f1  = m_busy[0] ? m_inc[0] : 0;
    e.f2  = m_busy[1] ? m_inc[1] : 0;
    e.vol = m_vol;
    e.ena = (e.f1 != 0 || e.f2 != 0) ? 1 : 0;
    return e;
  endfunction

  task automatic model_event(input int c, input bit b);
    int bs;
    int f;
    bit h0;
    bit h1;
    bs = base_of(c);
    h0 = m_busy[0] && m_code[0] == c;
    h1 = m_busy[1] && m_code[1] == c;
    if (bs != 0 && !b) begin
      if (!(h0 || h1)) begin
        if (m_oct >= 0) f = bs * (1 << m_oct);
        else f = bs / (1 << (-m_oct));
        if (!m_busy[0]) begin
          m_busy[0] = 1; m_code[0] = c; m_inc[0] = f;
          m_old = m_busy[1] ? 1 : 0;
        end else if (!m_busy[1]) begin
          m_busy[1] = 1; m_code[1] = c; m_inc[1] = f;
          m_old = 0;
        end else begin
          m_code[m_old] = c;
          m_inc[m_old]  = f;
          m_old = 1 - m_old;
        end
      end
    end else if (bs != 0 && b) begin
      if (h0) m_busy[0] = 0;
      if (h1) m_busy[1] = 0;
      if (h0 && m_busy[1]) m_old = 1;
    end else if (!b) begin
      if (c == 'h1A && m_oct > -2) m_oct--;
      if (c == 'h22 && m_oct < 2) m_oct++;
      if (c == 'h79) m_vol = (m_vol + 16 > 511) ? 511 : m_vol + 16;
      if (c == 'h7B) m_vol = (m_vol < 16) ? 0 : m_vol - 16;
    end
  endtask

  task automatic send(input int c, input bit b);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = 8'(c);
    bus.key_break = b;
    model_event(c, b);
    sb.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.key_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    idle(1);
    k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0",
               sb.size());
      sb.delete();
    end
  endtask

  task automatic check_now(input string nm);
    exp_t e;
    e = model_out();
    check({nm, ".f1"}, int'(bus.freq1), e.f1);
    check({nm, ".f2"}, int'(bus.freq2), e.f2);
    check({nm, ".vol"}, int'(bus.volume), e.vol);
    check({nm, ".ena"}, int'(bus.audio_ena), e.ena);
  endtask

  // Reset with a concurrent note make that must be dropped.
  task automatic do_reset(input int c);
    drain();
    @(negedge clk);
    reset         = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_code  = 8'(c);
    bus.key_break = 1'b0;
    @(negedge clk);
    reset         = 1'b0;
    bus.key_valid = 1'b0;
    model_reset();
    check_now("reset");
  endtask

  // Monitor: a strobe sampled outside reset yields one update.
  always @(posedge clk) begin
    exp_t e;
    bit v;
    v = bus.key_valid && !reset;
    if (v) begin
      #1;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: got update expected none");
      end else begin
        e = sb.pop_front();
        check("f1", int'(bus.freq1), e.f1);
        check("f2", int'(bus.freq2), e.f2);
        check("vol", int'(bus.volume), e.vol);
        check("ena", int'(bus.audio_ena), e.ena);
      end
    end
  end

  int codes[14] = '{'h1C, 'h1B, 'h23, 'h2B, 'h34, 'h33,
                    'h3B, 'h42, 'h1A, 'h22, 'h79, 'h7B,
                    'h55, 'h00};

  initial begin
    reset         = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = '0;
    bus.key_break = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(10);
    check_now("idle");

    send('h33, 0);
    send('h33, 0);
    send('h33, 1);
    drain();

    send('h1C, 0);
    send('h34, 0);
    send('h42, 0);
    send('h3B, 0);
    drain();
    do_reset('h33);

    send('h22, 0);
    send('h22, 0);
    send('h33, 0);
    for (int i = 0; i < 5; i++) send('h1A, 0);
    send('h1C, 0);
    drain();
    do_reset('h33);

    for (int i = 0; i < 7; i++) send('h79, 0);
    for (int i = 0; i < 40; i++) send('h7B, 0);
    send('h7B, 1);
    send('h55, 0);
    send('h55, 1);
    send('h33, 1);
    drain();
    do_reset('h33);
    idle(2);
    check_now("post_reset");

    for (int n = 0; n < 2000; n++) begin
      int c;
      bit b;
      c = codes[$urandom_range(13, 0)];
      b = ($urandom_range(9, 0) < 4);
      send(c, b);
      if ($urandom_range(3, 0) == 0)
        idle($urandom_range(2, 1));
      if (n % 400 == 399)
        do_reset(codes[$urandom_range(7, 0)]);
    end
    drain();
    check_now("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_voice_allocator.md
Name: key_voice_allocator

Overview:
- Sits directly upstream of the audio tone generator. Consumes decoded keyboard events (scan code plus make/break flag).
- Maps note keys to 16-bit phase increments and allocates them to two voice slots, driving the generator's freq1/freq2 inputs.
- Maintains the 9-bit volume word and an octave shift. Asserts audio_ena while any voice is sounding.
- Phase increments assume a 48 kHz DACLRCK and a 16-bit phase accumulator: inc = round(f*65536/48000).

Parameters:
- VOL_DEFAULT, 9'd400, volume after reset.
- VOL_STEP, 9'd16, volume change per volume key press.
- VOL_MAX, 9'd511, upper volume saturation; the lower bound is 0.

Ports:
- clk  input  1  system clock; the only clock domain.
- reset  input  1  synchronous, active-high reset.
- key_valid  input  1  single-cycle strobe; key_code and key_break are valid in this cycle.
- key_code  input  8  PS/2 set-2 scan code, with the E0/F0 prefixes already stripped.
- key_break  input  1  1 = key release, 0 = key press or typematic repeat.
- freq1  output  16  voice-1 phase increment; 0 = silent.
- freq2  output  16  voice-2 phase increment; 0 = silent.
- volume  output  9  codec volume word.
- audio_ena  output  1  1 while freq1!=0 or freq2!=0.

Behaviour:
- Reset state: freq1=0, freq2=0, volume=VOL_DEFAULT, audio_ena=0, octave=0, both slots free, oldest=slot1. Reset overrides a simultaneous key_valid.
- Events are processed only when key_valid=1. All outputs are registered and update on the clock edge at which key_valid is sampled (1-cycle latency). Back-to-back strobes are each processed in order; no stall.
- Base note table (scan code -> increment at octave 0):
  - 0x1C C4=357, 0x1B D4=401, 0x23 E4=450, 0x2B F4=477
  - 0x34 G4=535, 0x33 A4=601, 0x3B B4=674, 0x42 C5=714
- Octave keys:
  - 0x1A (Z) make: octave-1. 0x22 (X) make: octave+1.
  - Range is -2..+2; saturates at the limits. Breaks of these keys are ignored.
  - Effective increment = base<<octave for octave>=0, base>>|octave| for octave<0; the result stays 16-bit with no overflow, since 714<<2 = 2856.
  - The octave is latched per slot at allocation time. An octave change does not retune notes already sounding.
- Volume keys:
  - 0x79 (keypad +) make: volume = min(volume+VOL_STEP, VOL_MAX), computed 10-bit before saturation.
  - 0x7B (keypad -) make: volume = max(volume-VOL_STEP, 0), no underflow.
  - Typematic repeats step again. Breaks are ignored.
- Each slot holds {busy, key_code, increment}.
- Note make:
  - If the key is already held in either slot (typematic repeat), no change.
  - Else if slot1 is free: assign slot1, then oldest=slot2 if slot2 is busy, else oldest=slot1.
  - Else if slot2 is free: assign slot2, oldest=slot1.
  - Else steal the slot marked oldest, overwrite it, and flip oldest to the other slot.
- Note break: any slot holding that key_code is freed and its freq output is set to 0. If slot1 is freed while slot2 stays busy, oldest=slot2. A break for a code not held is a no-op.
- Unknown codes (make or break) are no-ops.
- freqN = slotN.busy ? slotN.increment : 0.
- audio_ena is registered, consistent with freq1/freq2 in the same cycle.

Test Plan:
- Reset, then idle 10 cycles -> freq1=0, freq2=0, volume=400, audio_ena=0.
- Make 0x33 -> next cycle freq1=601, audio_ena=1. Make 0x33 again -> unchanged. Break 0x33 -> freq1=0, audio_ena=0.
- Make 0x1C, then make 0x34, then make 0x42 -> freq1=357, freq2=535, then the steal gives freq1=714, freq2=535. Make 0x3B -> freq2=674 (the steal alternates).
- Make 0x22 twice, then make 0x33 -> freq1=2404. Make 0x1A five times, then make 0x1C -> freq2=357>>2=89, and freq1 stays 2404.
- Make 0x79 seven times from 400 -> volume 416, 432, ..., 511 (saturated). Make 0x7B 40 times -> volume reaches 0 and stays 0.
- key_valid with make 0x33 in the same cycle as reset=1 -> outputs hold reset values and no voice is allocated. Unknown code 0x55 make/break -> no output change.
